// File: rtl/fir_pkg.sv
// Shared helpers for the symmetric-FIR tap sequencer: width derivation and FSM state type.
package fir_pkg;

   typedef enum logic [0:0] {StIdle, StRun} fsm_state_e;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) r++;
      return r;
   endfunction

   function automatic int unsigned c_depth(input int unsigned n_taps);
      return (n_taps + 1) / 2;
   endfunction

   function automatic int unsigned groups(input int unsigned n_taps, input int unsigned lanes);
      return (c_depth(n_taps) + lanes - 1) / lanes;
   endfunction

   function automatic int unsigned g_width(input int unsigned n_taps, input int unsigned lanes);
      return (groups(n_taps, lanes) > 1) ? clog2(groups(n_taps, lanes)) : 1;
   endfunction

   function automatic int unsigned p_width(input int unsigned s_width);
      return s_width + 1;
   endfunction

endpackage

// File: rtl/fir_fold_lane.sv
// One MAC-lane feed: selects the symmetric tap pair (or centre tap, or zero pad) for the
// current group and pre-adds it at full precision, alongside the matching coefficient.
module fir_fold_lane
   import fir_pkg::*;
#(
   parameter int unsigned S_WIDTH = 24,
   parameter int unsigned C_WIDTH = 27,
   parameter int unsigned N_TAPS  = 29,
   parameter int unsigned LANES   = 5,
   parameter int unsigned LANE    = 0,
   localparam int unsigned C_DEPTH = c_depth(N_TAPS),
   localparam int unsigned G_W     = g_width(N_TAPS, LANES),
   localparam int unsigned P_WIDTH = p_width(S_WIDTH)
) (
   input  logic [N_TAPS*S_WIDTH-1:0]  win_i,
   input  logic [C_DEPTH*C_WIDTH-1:0] coef_i,
   input  logic [G_W-1:0]             g_i,
   output logic [P_WIDTH-1:0]         samp_o,
   output logic [C_WIDTH-1:0]         coef_o
);

   int unsigned        k;
   logic [S_WIDTH-1:0] near_s;
   logic [S_WIDTH-1:0] far_s;

   always_comb begin
      k      = LANES * 32'(g_i) + LANE;
      near_s = '0;
      far_s  = '0;
      samp_o = '0;
      coef_o = '0;
      if (k < N_TAPS / 2) begin
         near_s = win_i[k*S_WIDTH +: S_WIDTH];
         far_s  = win_i[(N_TAPS-1-k)*S_WIDTH +: S_WIDTH];
         samp_o = {near_s[S_WIDTH-1], near_s} + {far_s[S_WIDTH-1], far_s};
         coef_o = coef_i[k*C_WIDTH +: C_WIDTH];
      end else if ((N_TAPS % 2 == 1) && (k == C_DEPTH - 1)) begin
         // Centre tap of an odd-length filter has no mirror partner.
         near_s = win_i[k*S_WIDTH +: S_WIDTH];
         samp_o = {near_s[S_WIDTH-1], near_s};
         coef_o = coef_i[k*C_WIDTH +: C_WIDTH];
      end
   end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Captures one I/Q window per input handshake and streams folded taps plus coefficients to
// LANES MAC lanes over GROUPS beats, with back-to-back windows and flush.
module fir_tap_sequencer
   import fir_pkg::*;
#(
   parameter int unsigned S_WIDTH = 24,
   parameter int unsigned C_WIDTH = 27,
   parameter int unsigned N_TAPS  = 29,
   parameter int unsigned LANES   = 5,
   localparam int unsigned C_DEPTH = c_depth(N_TAPS),
   localparam int unsigned GROUPS  = groups(N_TAPS, LANES),
   localparam int unsigned G_W     = g_width(N_TAPS, LANES),
   localparam int unsigned P_WIDTH = p_width(S_WIDTH)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [N_TAPS*S_WIDTH-1:0]  samp_inI,
   input  logic [N_TAPS*S_WIDTH-1:0]  samp_inQ,
   input  logic [C_DEPTH*C_WIDTH-1:0] coef_inI,
   input  logic [C_DEPTH*C_WIDTH-1:0] coef_inQ,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [LANES*P_WIDTH-1:0]   samp_outI,
   output logic [LANES*P_WIDTH-1:0]   samp_outQ,
   output logic [LANES*C_WIDTH-1:0]   coef_outI,
   output logic [LANES*C_WIDTH-1:0]   coef_outQ,
   output logic [G_W-1:0]             out_group,
   output logic                       out_first,
   output logic                       out_last,
   output logic                       busy
);

   fsm_state_e                state_q, state_d;
   logic [G_W-1:0]            g_q, g_d;
   logic [N_TAPS*S_WIDTH-1:0] wini_q, wini_d;
   logic [N_TAPS*S_WIDTH-1:0] winq_q, winq_d;
   logic                      run, last_grp, in_accept, out_accept;

   logic [LANES*P_WIDTH-1:0]  lane_si, lane_sq;
   logic [LANES*C_WIDTH-1:0]  lane_ci, lane_cq;

   always_comb begin
      run        = (state_q == StRun);
      last_grp   = (g_q == G_W'(GROUPS - 1));
      in_ready   = ~reset & (~run | (out_ready & last_grp));
      in_accept  = in_valid & in_ready;
      out_accept = run & out_ready;

      state_d = state_q;
      g_d     = g_q;
      wini_d  = wini_q;
      winq_d  = winq_q;
      if (flush) begin
         state_d = StIdle;
         g_d     = '0;
         wini_d  = '0;
         winq_d  = '0;
      end else if (in_accept) begin
         // Covers both the idle capture and the same-cycle refill on the final beat.
         state_d = StRun;
         g_d     = '0;
         wini_d  = samp_inI;
         winq_d  = samp_inQ;
      end else if (out_accept) begin
         if (last_grp) begin
            state_d = StIdle;
            g_d     = '0;
         end else begin
            g_d = g_q + G_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         g_q     <= '0;
         wini_q  <= '0;
         winq_q  <= '0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         wini_q  <= wini_d;
         winq_q  <= winq_d;
      end
   end

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      fir_fold_lane #(
         .S_WIDTH (S_WIDTH),
         .C_WIDTH (C_WIDTH),
         .N_TAPS  (N_TAPS),
         .LANES   (LANES),
         .LANE    (j)
      ) u_lane_i (
         .win_i  (wini_q),
         .coef_i (coef_inI),
         .g_i    (g_q),
         .samp_o (lane_si[j*P_WIDTH +: P_WIDTH]),
         .coef_o (lane_ci[j*C_WIDTH +: C_WIDTH])
      );

      fir_fold_lane #(
         .S_WIDTH (S_WIDTH),
         .C_WIDTH (C_WIDTH),
         .N_TAPS  (N_TAPS),
         .LANES   (LANES),
         .LANE    (j)
      ) u_lane_q (
         .win_i  (winq_q),
         .coef_i (coef_inQ),
         .g_i    (g_q),
         .samp_o (lane_sq[j*P_WIDTH +: P_WIDTH]),
         .coef_o (lane_cq[j*C_WIDTH +: C_WIDTH])
      );
   end

   always_comb begin
      out_valid = run;
      busy      = run;
      out_first = run & (g_q == '0);
      out_last  = run & last_grp;
      out_group = run ? g_q : '0;
      samp_outI = run ? lane_si : '0;
      samp_outQ = run ? lane_sq : '0;
      coef_outI = run ? lane_ci : '0;
      coef_outQ = run ? lane_cq : '0;
   end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Scoreboard bench: three sequencer configurations (29/5, 16/3, 9/5) driven side by side.
`define TICK begin @(posedge clk); #1; end

module tb_fir_tap_sequencer;

   localparam int SW = 24;
   localparam int CW = 27;
   localparam int PW = 25;

   typedef struct packed {
      logic [255:0] si;
      logic [255:0] sq;
      logic [255:0] ci;
      logic [255:0] cq;
      logic [7:0]   grp;
      logic         fst;
      logic         lst;
   } beat_t;

   logic clk;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic beat_t model(input logic [29*SW-1:0] wi, input logic [29*SW-1:0] wq,
                                   input logic [15*CW-1:0] ci, input logic [15*CW-1:0] cq,
                                   input int nt, input int nl, input int ng, input int g);
      beat_t             b;
      int                k, cd;
      logic signed [31:0] a, q;
      b  = '0;
      cd = (nt + 1) / 2;
      for (int j = 0; j < nl; j++) begin
         k = g * nl + j;
         if (k < nt / 2) begin
            a = 32'($signed(wi[k*SW +: SW])) + 32'($signed(wi[(nt-1-k)*SW +: SW]));
            q = 32'($signed(wq[k*SW +: SW])) + 32'($signed(wq[(nt-1-k)*SW +: SW]));
            b.si[j*PW +: PW] = a[PW-1:0];
            b.sq[j*PW +: PW] = q[PW-1:0];
            b.ci[j*CW +: CW] = ci[k*CW +: CW];
            b.cq[j*CW +: CW] = cq[k*CW +: CW];
         end else if ((nt % 2 == 1) && (k == cd - 1)) begin
            a = 32'($signed(wi[k*SW +: SW]));
            q = 32'($signed(wq[k*SW +: SW]));
            b.si[j*PW +: PW] = a[PW-1:0];
            b.sq[j*PW +: PW] = q[PW-1:0];
            b.ci[j*CW +: CW] = ci[k*CW +: CW];
            b.cq[j*CW +: CW] = cq[k*CW +: CW];
         end
      end
      b.grp = 8'(g);
      b.fst = (g == 0);
      b.lst = (g == ng - 1);
      return b;
   endfunction

   for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
      localparam int NT = (gi == 0) ? 29 : (gi == 1) ? 16 : 9;
      localparam int NL = (gi == 1) ? 3 : 5;
      localparam int CD = (NT + 1) / 2;
      localparam int NG = (CD + NL - 1) / NL;
      localparam int GW = (NG > 1) ? $clog2(NG) : 1;

      logic               rst, fl, iv, ir, ov, orr, of, ol, by;
      logic [NT*SW-1:0]   wi, wq;
      logic [CD*CW-1:0]   ci, cq;
      logic [NL*PW-1:0]   so_i, so_q;
      logic [NL*CW-1:0]   co_i, co_q;
      logic [GW-1:0]      og;
      logic               done = 1'b0;
      beat_t              q[$];
      beat_t              e;
      logic               ev, acc;
      int                 n, t0, t1;

      fir_tap_sequencer #(
         .S_WIDTH (SW),
         .C_WIDTH (CW),
         .N_TAPS  (NT),
         .LANES   (NL)
      ) u_dut (
         .clk       (clk),
         .reset     (rst),
         .flush     (fl),
         .in_valid  (iv),
         .in_ready  (ir),
         .samp_inI  (wi),
         .samp_inQ  (wq),
         .coef_inI  (ci),
         .coef_inQ  (cq),
         .out_valid (ov),
         .out_ready (orr),
         .samp_outI (so_i),
         .samp_outQ (so_q),
         .coef_outI (co_i),
         .coef_outQ (co_q),
         .out_group (og),
         .out_first (of),
         .out_last  (ol),
         .busy      (by)
      );

      always @(negedge clk) begin
         if (rst) begin
            check_eq($sformatf("c%0d_rst_in_ready", gi), 256'(ir), 256'(0));
            q.delete();
         end else begin
            ev = (q.size() != 0);
            e  = ev ? q[0] : '0;
            check_eq($sformatf("c%0d_out_valid", gi), 256'(ov), 256'(ev));
            check_eq($sformatf("c%0d_busy", gi), 256'(by), 256'(ev));
            check_eq($sformatf("c%0d_in_ready", gi), 256'(ir),
                     256'(!ev || (orr && q.size() == 1)));
            check_eq($sformatf("c%0d_samp_i", gi), 256'(so_i), e.si);
            check_eq($sformatf("c%0d_samp_q", gi), 256'(so_q), e.sq);
            check_eq($sformatf("c%0d_coef_i", gi), 256'(co_i), e.ci);
            check_eq($sformatf("c%0d_coef_q", gi), 256'(co_q), e.cq);
            check_eq($sformatf("c%0d_group", gi), 256'(og), 256'(e.grp));
            check_eq($sformatf("c%0d_first", gi), 256'(of), 256'(e.fst));
            check_eq($sformatf("c%0d_last", gi), 256'(ol), 256'(e.lst));
            if (fl) begin
               q.delete();
            end else begin
               if (ev && orr) e = q.pop_front();
               if (iv && ir)
                  for (int g = 0; g < NG; g++)
                     q.push_back(model(696'(wi), 696'(wq), 405'(ci), 405'(cq), NT, NL, NG, g));
            end
         end
      end

      initial begin
         rst = 1'b1; fl = 1'b0; iv = 1'b0; orr = 1'b1; wi = '0; wq = '0;
         for (int k = 0; k < CD; k++) begin
            ci[k*CW +: CW] = CW'(100 + k);
            cq[k*CW +: CW] = CW'(-(200 + k));
         end
         repeat (3) `TICK
         rst = 1'b0;

         // Ramp, extreme-value and random windows; ready held, toggled, then random.
         for (int p = 0; p < 10; p++) begin
            for (int i = 0; i < NT; i++) begin
               case (p)
                  0: begin wi[i*SW +: SW] = SW'(i); wq[i*SW +: SW] = SW'(-i); end
                  1: begin wi[i*SW +: SW] = {1'b1, {(SW-1){1'b0}}}; wq[i*SW +: SW] = '1; end
                  2: begin wi[i*SW +: SW] = {1'b0, {(SW-1){1'b1}}}; wq[i*SW +: SW] = '0; end
                  default: begin wi[i*SW +: SW] = SW'($urandom); wq[i*SW +: SW] = SW'($urandom); end
               endcase
            end
            iv  = 1'b1;
            acc = 1'b0;
            for (n = 0; n < 64 && !acc; n++) begin
               orr = (p < 3) ? 1'b1 : (p < 6) ? ~orr : 1'($urandom_range(0, 1));
               @(negedge clk);
               acc = ir;
               `TICK
            end
            if (!acc) check_eq($sformatf("c%0d_accept_timeout", gi), 256'(0), 256'(1));
         end
         iv  = 1'b0;
         orr = 1'b1;
         for (n = 0; n < 64 && (ov || q.size() != 0); n++) @(negedge clk);
         check_eq($sformatf("c%0d_drain", gi), 256'(ov), 256'(0));
         `TICK

         // Three windows back to back with the consumer always ready.
         for (int i = 0; i < NT; i++) wi[i*SW +: SW] = SW'($urandom);
         iv = 1'b1;
         `TICK
         t0 = cyc;
         for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < NT; i++) wq[i*SW +: SW] = SW'($urandom);
            acc = 1'b0;
            for (n = 0; n < 64 && !acc; n++) begin
               @(negedge clk);
               acc = ir;
               `TICK
            end
            if (!acc) check_eq($sformatf("c%0d_b2b_timeout", gi), 256'(0), 256'(1));
         end
         iv = 1'b0;
         for (n = 0; n < 64; n++) begin
            @(negedge clk);
            if (!ov) break;
         end
         t1 = cyc;
         check_eq($sformatf("c%0d_throughput", gi), 256'(t1 - t0), 256'(3 * NG));
         `TICK

         // Flush mid-window while a new window is offered, then restart.
         for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NT; i++) wi[i*SW +: SW] = SW'(i * 3 + r);
            iv = 1'b1;
            `TICK
            iv = 1'b0;
            if (NG > 1) `TICK
            for (int i = 0; i < NT; i++) wi[i*SW +: SW] = SW'($urandom);
            iv = 1'b1;
            if (r == 0) fl = 1'b1; else rst = 1'b1;
            `TICK
            fl  = 1'b0;
            rst = 1'b0;
            iv  = 1'b0;
            @(negedge clk);
            check_eq($sformatf("c%0d_abort_valid_%0d", gi, r), 256'(ov), 256'(0));
            check_eq($sformatf("c%0d_abort_ready_%0d", gi, r), 256'(ir), 256'(1));
            `TICK
            iv = 1'b1;
            `TICK
            iv = 1'b0;
            for (n = 0; n < 64 && (ov || q.size() != 0); n++) @(negedge clk);
            check_eq($sformatf("c%0d_restart_drain_%0d", gi, r), 256'(ov), 256'(0));
            `TICK
         end
         done = 1'b1;
      end
   end

   initial begin
      for (int n = 0; n < 20000; n++) begin
         @(posedge clk);
         if (g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) break;
      end
      if (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done))
         check_eq("global_timeout", 256'(0), 256'(1));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
